// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite single-transfer responder backed by a word-addressed register bank.
// Checks each address phase, inserts WAIT_STATES wait cycles and answers OKAY, or gives a two-cycle ERROR.
module ahb_lite_mem_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL_m_s,
    input  logic [ADDR_WIDTH-1:0] HADDR_m_s,
    input  logic                  HWRITE_m_s,
    input  logic [2:0]            HSIZE_m_s,
    input  logic [2:0]            HBURST_m_s,
    input  logic [1:0]            HTRANS_m_s,
    input  logic [DATA_WIDTH-1:0] HWDATA_m_s,
    output logic                  HREADY_s_m,
    output logic                  HRESP_s_m,
    output logic [DATA_WIDTH-1:0] HRDATA_s_m
);

    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] SPAN    = (ADDR_WIDTH+1)'(DEPTH * 4);
    localparam logic [3:0]          WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [IDX_W-1:0]        idx_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        acc_idx;
    logic                    addr_err;
    logic                    accept;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   rd_fwd;
    logic                    unused_inputs;

    // Burst type is irrelevant (every transfer is SINGLE); HTRANS[0] only splits IDLE/BUSY and NONSEQ/SEQ.
    assign unused_inputs = ^{HBURST_m_s, HTRANS_m_s[0]};

    assign offset   = HADDR_m_s - BASE_ADDR;
    assign acc_idx  = offset[IDX_W+1:2];
    assign addr_err = (HADDR_m_s[1:0] != 2'b00) || (HSIZE_m_s != 3'b010) ||
                      (HADDR_m_s < BASE_ADDR) || ({1'b0, offset} >= SPAN);
    assign accept   = HREADY_s_m && HSEL_m_s && HTRANS_m_s[1];
    assign commit   = (state == ST_DATA) && wr_q;

    // A read accepted on the edge that commits a write to the same word sees the new data.
    assign rd_fwd   = (commit && (idx_q == acc_idx)) ? HWDATA_m_s : mem[acc_idx];

    always_ff @(posedge HCLK) begin
        if (!HRESET && commit)
            mem[idx_q] <= HWDATA_m_s;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            HREADY_s_m <= 1'b1;
            HRESP_s_m  <= 1'b0;
            HRDATA_s_m <= '0;
            wait_cnt   <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state      <= ST_DATA;
                        HREADY_s_m <= 1'b1;
                        HRESP_s_m  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    HREADY_s_m <= 1'b1;
                    HRESP_s_m  <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        idx_q <= acc_idx;
                        wr_q  <= HWRITE_m_s && !addr_err;
                        if (addr_err) begin
                            state      <= ST_ERR1;
                            HREADY_s_m <= 1'b0;
                            HRESP_s_m  <= 1'b1;
                        end else begin
                            if (!HWRITE_m_s)
                                HRDATA_s_m <= rd_fwd;
                            HRESP_s_m <= 1'b0;
                            if (WAIT_STATES > 0) begin
                                state      <= ST_WAIT;
                                wait_cnt   <= WS_INIT;
                                HREADY_s_m <= 1'b0;
                            end else begin
                                state      <= ST_DATA;
                                HREADY_s_m <= 1'b1;
                            end
                        end
                    end else begin
                        state      <= ST_IDLE;
                        HREADY_s_m <= 1'b1;
                        HRESP_s_m  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3) driven one at a time with hand-computed expectations.
module tb_ahb_lite_mem_slave;

    logic        hclk;
    logic        hreset;
    logic        hsel   [3];
    logic [31:0] haddr  [3];
    logic        hwrite [3];
    logic [2:0]  hsize  [3];
    logic [2:0]  hburst [3];
    logic [1:0]  htrans [3];
    logic [31:0] hwdata [3];
    logic        hready [3];
    logic        hresp  [3];
    logic [31:0] hrdata [3];

    int checks = 0;
    int errors = 0;

    ahb_lite_mem_slave #(.WAIT_STATES(1)) u_ws1 (
        .HCLK(hclk), .HRESET(hreset), .HSEL_m_s(hsel[0]), .HADDR_m_s(haddr[0]),
        .HWRITE_m_s(hwrite[0]), .HSIZE_m_s(hsize[0]), .HBURST_m_s(hburst[0]),
        .HTRANS_m_s(htrans[0]), .HWDATA_m_s(hwdata[0]), .HREADY_s_m(hready[0]),
        .HRESP_s_m(hresp[0]), .HRDATA_s_m(hrdata[0]));

    ahb_lite_mem_slave #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL_m_s(hsel[1]), .HADDR_m_s(haddr[1]),
        .HWRITE_m_s(hwrite[1]), .HSIZE_m_s(hsize[1]), .HBURST_m_s(hburst[1]),
        .HTRANS_m_s(htrans[1]), .HWDATA_m_s(hwdata[1]), .HREADY_s_m(hready[1]),
        .HRESP_s_m(hresp[1]), .HRDATA_s_m(hrdata[1]));

    ahb_lite_mem_slave #(.WAIT_STATES(3)) u_ws3 (
        .HCLK(hclk), .HRESET(hreset), .HSEL_m_s(hsel[2]), .HADDR_m_s(haddr[2]),
        .HWRITE_m_s(hwrite[2]), .HSIZE_m_s(hsize[2]), .HBURST_m_s(hburst[2]),
        .HTRANS_m_s(htrans[2]), .HWDATA_m_s(hwdata[2]), .HREADY_s_m(hready[2]),
        .HRESP_s_m(hresp[2]), .HRDATA_s_m(hrdata[2]));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic addr_ph(input int i, input logic [31:0] a, input logic wr, input logic [2:0] sz);
        hsel[i]   = 1'b1;
        haddr[i]  = a;
        hwrite[i] = wr;
        hsize[i]  = sz;
        htrans[i] = 2'b10;
    endtask

    task automatic idle_ph(input int i);
        hsel[i]   = 1'b0;
        haddr[i]  = '0;
        hwrite[i] = 1'b0;
        hsize[i]  = 3'b010;
        htrans[i] = 2'b00;
    endtask

    // Full transfer; returns after the completing edge. waits counts HREADY-low cycles (bounded).
    task automatic xfer(input int i, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits, output logic resp);
        addr_ph(i, a, wr, 3'b010);
        cyc();
        idle_ph(i);
        hwdata[i] = wd;
        waits = 0;
        while (!hready[i] && waits < 32) begin
            waits++;
            cyc();
        end
        rd   = hrdata[i];
        resp = hresp[i];
        cyc();
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        logic        r;

        for (int i = 0; i < 3; i++) begin
            idle_ph(i);
            hburst[i] = 3'b000;
            hwdata[i] = '0;
        end
        hreset = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("reset hready", 32'(hready[i]), 32'd1);
            chk("reset hresp",  32'(hresp[i]),  32'd0);
            chk("reset hrdata", hrdata[i],      32'd0);
        end
        hreset = 1'b0;

        // WAIT_STATES=1: write then read 0x10
        addr_ph(0, 32'h10, 1'b1, 3'b010);
        cyc();
        chk("ws1 wr wait hready", 32'(hready[0]), 32'd0);
        chk("ws1 wr wait hresp",  32'(hresp[0]),  32'd0);
        idle_ph(0);
        hwdata[0] = 32'hDEAD_BEEF;
        cyc();
        chk("ws1 wr done hready", 32'(hready[0]), 32'd1);
        chk("ws1 wr done hresp",  32'(hresp[0]),  32'd0);
        cyc();
        addr_ph(0, 32'h10, 1'b0, 3'b010);
        cyc();
        chk("ws1 rd wait hready", 32'(hready[0]), 32'd0);
        idle_ph(0);
        cyc();
        chk("ws1 rd done hready", 32'(hready[0]), 32'd1);
        chk("ws1 rd done hresp",  32'(hresp[0]),  32'd0);
        chk("ws1 rd data",        hrdata[0],      32'hDEAD_BEEF);
        cyc();
        chk("ws1 idle hready",    32'(hready[0]), 32'd1);

        // WAIT_STATES=0: back-to-back write/read with bypass
        addr_ph(1, 32'h20, 1'b1, 3'b010);
        cyc();
        chk("ws0 wr done hready", 32'(hready[1]), 32'd1);
        hwdata[1] = 32'h1234_5678;
        addr_ph(1, 32'h20, 1'b0, 3'b010);
        cyc();
        chk("ws0 rd done hready", 32'(hready[1]), 32'd1);
        chk("ws0 rd hresp",       32'(hresp[1]),  32'd0);
        chk("ws0 bypass data",    hrdata[1],      32'h1234_5678);
        idle_ph(1);
        cyc();
        chk("ws0 idle hready",    32'(hready[1]), 32'd1);

        // Errors: misaligned read, out-of-range write; mem[0] untouched
        xfer(0, 32'h0, 1'b1, 32'hA5A5_A5A5, rd, w, r);
        chk("seed mem0 waits", 32'(w), 32'd1);
        chk("seed mem0 resp",  32'(r), 32'd0);
        addr_ph(0, 32'h402, 1'b0, 3'b010);
        cyc();
        chk("mis err1 hready", 32'(hready[0]), 32'd0);
        chk("mis err1 hresp",  32'(hresp[0]),  32'd1);
        idle_ph(0);
        cyc();
        chk("mis err2 hready", 32'(hready[0]), 32'd1);
        chk("mis err2 hresp",  32'(hresp[0]),  32'd1);
        cyc();
        chk("mis idle hready", 32'(hready[0]), 32'd1);
        chk("mis idle hresp",  32'(hresp[0]),  32'd0);
        chk("mis hrdata held", hrdata[0],      32'hDEAD_BEEF);
        addr_ph(0, 32'h400, 1'b1, 3'b010);
        cyc();
        chk("oor err1 hready", 32'(hready[0]), 32'd0);
        chk("oor err1 hresp",  32'(hresp[0]),  32'd1);
        idle_ph(0);
        hwdata[0] = 32'hFFFF_FFFF;
        cyc();
        chk("oor err2 hready", 32'(hready[0]), 32'd1);
        chk("oor err2 hresp",  32'(hresp[0]),  32'd1);
        cyc();
        chk("oor idle hready", 32'(hready[0]), 32'd1);
        chk("oor idle hresp",  32'(hresp[0]),  32'd0);
        xfer(0, 32'h0, 1'b0, 32'h0, rd, w, r);
        chk("mem0 unchanged", rd, 32'hA5A5_A5A5);

        // Illegal HSIZE read
        addr_ph(0, 32'h04, 1'b0, 3'b000);
        cyc();
        chk("size err1 hready", 32'(hready[0]), 32'd0);
        chk("size err1 hresp",  32'(hresp[0]),  32'd1);
        idle_ph(0);
        cyc();
        chk("size err2 hready", 32'(hready[0]), 32'd1);
        chk("size err2 hresp",  32'(hresp[0]),  32'd1);
        chk("size hrdata held", hrdata[0],      32'hA5A5_A5A5);
        cyc();
        chk("size idle hresp",  32'(hresp[0]),  32'd0);

        // No-accept cases: BUSY, and NONSEQ with HSEL low
        addr_ph(0, 32'h10, 1'b0, 3'b010);
        htrans[0] = 2'b01;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("busy hready", 32'(hready[0]), 32'd1);
            chk("busy hresp",  32'(hresp[0]),  32'd0);
        end
        htrans[0] = 2'b10;
        hsel[0]   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("nosel hready", 32'(hready[0]), 32'd1);
            chk("nosel hresp",  32'(hresp[0]),  32'd0);
        end
        chk("noacc hrdata held", hrdata[0], 32'hA5A5_A5A5);
        idle_ph(0);

        // WAIT_STATES=3: reset in the second wait cycle of a write
        xfer(2, 32'h08, 1'b1, 32'h0BAD_F00D, rd, w, r);
        chk("ws3 seed waits", 32'(w), 32'd3);
        addr_ph(2, 32'h08, 1'b1, 3'b010);
        cyc();
        chk("ws3 wait1 hready", 32'(hready[2]), 32'd0);
        idle_ph(2);
        hwdata[2] = 32'h1111_1111;
        cyc();
        chk("ws3 wait2 hready", 32'(hready[2]), 32'd0);
        hreset = 1'b1;
        cyc();
        chk("ws3 rst hready", 32'(hready[2]), 32'd1);
        chk("ws3 rst hresp",  32'(hresp[2]),  32'd0);
        chk("ws3 rst hrdata", hrdata[2],      32'd0);
        hreset = 1'b0;
        xfer(2, 32'h08, 1'b0, 32'h0, rd, w, r);
        chk("ws3 rd waits",   32'(w), 32'd3);
        chk("ws3 rd resp",    32'(r), 32'd0);
        chk("ws3 mem2 kept",  rd,     32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
